updown_sweep_ctrl: RTL and testbench
====================================

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 4, bit width of Count, lo, hi.
REQ-002 SHALL have port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a sweep program; sampled only in IDLE.
REQ-005 SHALL have port: abort  input  1  terminate an active program.
REQ-006 SHALL have port: lo  input  WIDTH  lower sweep bound, captured on accept.
REQ-007 SHALL have port: hi  input  WIDTH  upper sweep bound, captured on accept.
REQ-008 SHALL have port: sweeps  input  4  number of lo->hi->lo sweeps, captured on accept.
REQ-009 SHALL have port: Count  output  WIDTH  up/down counter value.
REQ-010 SHALL have port: UpOrDown  output  1  current direction; 1 = up, 0 = down.
REQ-011 SHALL have port: busy  output  1  program active.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on normal completion.
REQ-013 SHALL have port: cfg_err  output  1  one-cycle pulse on rejected start.
REQ-014 SHALL have port: sweep_cnt  output  4  completed sweeps in current/last program.

Function
REQ-015 SHALL implement two states: IDLE (busy=0) and RUN (busy=1); all outputs registered.
REQ-016 In IDLE, start=1, abort=0, lo<hi, sweeps!=0 SHALL at that edge: capture lo/hi/sweeps, Count<=lo, UpOrDown<=1, sweep_cnt<=0, busy<=1, go to RUN.
REQ-017 In IDLE, start=1, abort=0 with lo>=hi or sweeps==0 SHALL pulse cfg_err for one cycle, stay IDLE, leave Count/UpOrDown/sweep_cnt unchanged.
REQ-018 In IDLE, start=1 with abort=1 SHALL be ignored (no accept, no cfg_err).
REQ-019 In IDLE, Count and UpOrDown SHALL hold.
REQ-020 In RUN, UpOrDown=1, Count!=hi SHALL give Count<=Count+1.
REQ-021 In RUN, UpOrDown=1, Count==hi SHALL hold Count for that edge and set UpOrDown<=0 (turnaround cycle).
REQ-022 In RUN, UpOrDown=0, Count!=lo SHALL give Count<=Count-1.
REQ-023 In RUN, UpOrDown=0, Count==lo SHALL hold Count and set sweep_cnt<=sweep_cnt+1.
REQ-024 In the REQ-023 case, if sweep_cnt+1==captured sweeps, SHALL go to IDLE, busy<=0, done<=1 for one cycle, UpOrDown<=0.
REQ-025 In the REQ-023 case otherwise, SHALL set UpOrDown<=1 and remain in RUN.
REQ-026 Each sweep SHALL take exactly 2*(hi-lo)+2 cycles; busy SHALL be high for sweeps*(2*(hi-lo)+2) cycles.
REQ-027 Count SHALL never leave [lo,hi] during RUN; no wrap-around occurs (including lo=0, hi=2^WIDTH-1).
REQ-028 start asserted during RUN SHALL be ignored; lo/hi/sweeps changes during RUN SHALL have no effect.
REQ-029 abort=1 in RUN SHALL at that edge go to IDLE, busy<=0, no done pulse; Count, UpOrDown, sweep_cnt hold.
REQ-030 abort SHALL take priority over completion in the same cycle (no done pulse).
REQ-031 done and cfg_err SHALL never be high simultaneously, and each SHALL be high for at most one cycle per event.

Reset
REQ-032 reset=1 SHALL immediately, without waiting for Clk, force IDLE, Count=0, UpOrDown=0, busy=0, done=0, cfg_err=0, sweep_cnt=0.
REQ-033 reset asserted mid-RUN SHALL abandon the program with no done pulse; after release, block SHALL accept a new start normally.

Verification
REQ-034 lo=2, hi=4, sweeps=1, start pulse -> Count per cycle 2,3,4,4,3,2; busy high 6 cycles; done pulse with Count=2, sweep_cnt=1.
REQ-035 lo=0, hi=15, sweeps=3 -> busy 96 cycles, Count stays within 0..15 (no wrap), sweep_cnt steps 1,2,3, single done pulse.
REQ-036 start with lo=5, hi=5 and again with sweeps=0 -> cfg_err one-cycle pulse each time, busy stays 0, Count unchanged.
REQ-037 lo=1, hi=6, sweeps=2, abort asserted when Count=4 descending in sweep 1 -> busy drops next edge, no done, Count=4, sweep_cnt=0 held.
REQ-038 reset pulsed mid-RUN between clock edges -> all outputs 0 immediately; subsequent start lo=3, hi=5, sweeps=1 completes in 6 cycles.
REQ-039 start re-pulsed with new lo/hi during RUN -> ignored; original sequence and done timing unchanged.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Bounded up/down sweep controller: counts lo->hi->lo a programmed number of times,
// with a turnaround hold cycle at each bound, abort, and config-error reporting.
module updown_sweep_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [3:0]       sweeps,
   output logic [WIDTH-1:0] Count,
   output logic             UpOrDown,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [3:0]       sweep_cnt
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cfg_err_q, cfg_err_d;
   logic [3:0]       sweep_cnt_q, sweep_cnt_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [3:0]       sweeps_q, sweeps_d;

   logic             cfg_ok;
   logic [3:0]       sweep_next;

   assign cfg_ok     = (lo < hi) && (sweeps != 4'd0);
   assign sweep_next = sweep_cnt_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      dir_d       = dir_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
      sweep_cnt_d = sweep_cnt_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      sweeps_d    = sweeps_q;

      unique case (state_q)
         StIdle: begin
            // start together with abort is dropped entirely
            if (start && !abort) begin
               if (cfg_ok) begin
                  lo_d        = lo;
                  hi_d        = hi;
                  sweeps_d    = sweeps;
                  count_d     = lo;
                  dir_d       = 1'b1;
                  sweep_cnt_d = 4'd0;
                  busy_d      = 1'b1;
                  state_d     = StRun;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (dir_q) begin
               if (count_q != hi_q) begin
                  count_d = count_q + WIDTH'(1);
               end else begin
                  dir_d = 1'b0;
               end
            end else if (count_q != lo_q) begin
               count_d = count_q - WIDTH'(1);
            end else begin
               // Bottom turnaround closes one sweep
               sweep_cnt_d = sweep_next;
               if (sweep_next == sweeps_q) begin
                  dir_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  dir_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         dir_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         sweep_cnt_q <= 4'd0;
         lo_q        <= '0;
         hi_q        <= '0;
         sweeps_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         dir_q       <= dir_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
         sweep_cnt_q <= sweep_cnt_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         sweeps_q    <= sweeps_d;
      end
   end

   assign Count     = count_q;
   assign UpOrDown  = dir_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;
   assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl: hand-computed count sequences, error pulses,
// abort, asynchronous reset and restart-ignore scenarios.
module tb_updown_sweep_ctrl;

   logic       Clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic [3:0] lo;
   logic [3:0] hi;
   logic [3:0] sweeps;
   logic [3:0] Count;
   logic       UpOrDown;
   logic       busy;
   logic       done;
   logic       cfg_err;
   logic [3:0] sweep_cnt;

   int n_vec = 0;
   int n_err = 0;

   updown_sweep_ctrl #(.WIDTH(4)) dut (
      .Clk       (Clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .lo        (lo),
      .hi        (hi),
      .sweeps    (sweeps),
      .Count     (Count),
      .UpOrDown  (UpOrDown),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err),
      .sweep_cnt (sweep_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance one edge and settle 1 time unit past it before sampling.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; lo = 4'd0; hi = 4'd0; sweeps = 4'd0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      n_vec++;
      if ({Count, UpOrDown, busy, done, cfg_err, sweep_cnt} !== 12'd0) begin
         $display("FAIL reset_state: got Count=%0d dir=%0b busy=%0b done=%0b cfg_err=%0b sc=%0d, want all 0",
                  Count, UpOrDown, busy, done, cfg_err, sweep_cnt);
         n_err++;
      end
   endtask

   task automatic test_basic();
      logic [3:0] exp_cnt [6] = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2};
      logic       exp_dir [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      lo = 4'd2; hi = 4'd4; sweeps = 4'd1; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         start = 1'b0;
         n_vec++;
         if (Count !== exp_cnt[i] || UpOrDown !== exp_dir[i] || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL basic_cycle%0d: got Count=%0d dir=%0b busy=%0b done=%0b, want Count=%0d dir=%0b busy=1 done=0",
                     i, Count, UpOrDown, busy, done, exp_cnt[i], exp_dir[i]);
            n_err++;
         end
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b1 || Count !== 4'd2 || sweep_cnt !== 4'd1 || UpOrDown !== 1'b0) begin
         $display("FAIL basic_done: got busy=%0b done=%0b Count=%0d sc=%0d dir=%0b, want 0 1 2 1 0",
                  busy, done, Count, sweep_cnt, UpOrDown);
         n_err++;
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || Count !== 4'd2) begin
         $display("FAIL basic_done_single: got done=%0b Count=%0d, want done=0 Count=2", done, Count);
         n_err++;
      end
   endtask

   task automatic test_full_range();
      int         nbusy = 1;
      int         ndone = 0;
      int         nwrap = 0;
      int         nsc_bad = 0;
      int         diff;
      logic [3:0] prev_cnt;
      logic [3:0] prev_sc;
      lo = 4'd0; hi = 4'd15; sweeps = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      prev_cnt = Count;
      prev_sc  = sweep_cnt;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (done) ndone++;
         if (busy) nbusy++;
         diff = int'(Count) - int'(prev_cnt);
         if (diff > 1 || diff < -1) nwrap++;
         if (sweep_cnt != prev_sc && sweep_cnt != prev_sc + 4'd1) nsc_bad++;
         prev_cnt = Count;
         prev_sc  = sweep_cnt;
         if (!busy) break;
      end
      tick();
      if (done) ndone++;
      n_vec++;
      if (nbusy != 96) begin
         $display("FAIL full_busy_cycles: got %0d, want 96", nbusy);
         n_err++;
      end
      n_vec++;
      if (nwrap != 0) begin
         $display("FAIL full_no_wrap: got %0d jumps, want 0", nwrap);
         n_err++;
      end
      n_vec++;
      if (nsc_bad != 0 || sweep_cnt !== 4'd3) begin
         $display("FAIL full_sweep_cnt: got bad_steps=%0d final=%0d, want 0 and 3", nsc_bad, sweep_cnt);
         n_err++;
      end
      n_vec++;
      if (ndone != 1) begin
         $display("FAIL full_done_pulses: got %0d, want 1", ndone);
         n_err++;
      end
   endtask

   task automatic test_cfg_err();
      logic [3:0] cnt_before;
      cnt_before = Count;
      lo = 4'd5; hi = 4'd5; sweeps = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || Count !== cnt_before || done !== 1'b0) begin
         $display("FAIL cfg_lo_eq_hi: got cfg_err=%0b busy=%0b Count=%0d done=%0b, want 1 0 %0d 0",
                  cfg_err, busy, Count, done, cnt_before);
         n_err++;
      end
      tick();
      n_vec++;
      if (cfg_err !== 1'b0) begin
         $display("FAIL cfg_pulse_width: got cfg_err=%0b, want 0", cfg_err);
         n_err++;
      end
      lo = 4'd1; hi = 4'd3; sweeps = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || Count !== cnt_before) begin
         $display("FAIL cfg_zero_sweeps: got cfg_err=%0b busy=%0b Count=%0d, want 1 0 %0d",
                  cfg_err, busy, Count, cnt_before);
         n_err++;
      end
      tick();
      lo = 4'd1; hi = 4'd3; sweeps = 4'd1; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      n_vec++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || Count !== cnt_before) begin
         $display("FAIL start_with_abort: got cfg_err=%0b busy=%0b Count=%0d, want 0 0 %0d",
                  cfg_err, busy, Count, cnt_before);
         n_err++;
      end
   endtask

   task automatic test_abort();
      bit found = 1'b0;
      lo = 4'd1; hi = 4'd6; sweeps = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      // Sequence 1,2,3,4,5,6,6,5,4: descending 4 reached 8 edges after accept
      for (int i = 0; i < 20; i++) begin
         if (Count == 4'd4 && UpOrDown == 1'b0) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      n_vec++;
      if (!found) begin
         $display("FAIL abort_reach_point: got Count=%0d dir=%0b, want Count=4 dir=0", Count, UpOrDown);
         n_err++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || Count !== 4'd4 || sweep_cnt !== 4'd0 || UpOrDown !== 1'b0) begin
         $display("FAIL abort_state: got busy=%0b done=%0b Count=%0d sc=%0d dir=%0b, want 0 0 4 0 0",
                  busy, done, Count, sweep_cnt, UpOrDown);
         n_err++;
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || Count !== 4'd4) begin
         $display("FAIL abort_no_done: got done=%0b busy=%0b Count=%0d, want 0 0 4", done, busy, Count);
         n_err++;
      end
   endtask

   task automatic test_reset_mid_run();
      int nbusy = 0;
      int ndone = 0;
      lo = 4'd1; hi = 4'd9; sweeps = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if ({Count, UpOrDown, busy, done, cfg_err, sweep_cnt} !== 12'd0) begin
         $display("FAIL async_reset: got Count=%0d dir=%0b busy=%0b done=%0b cfg_err=%0b sc=%0d, want all 0",
                  Count, UpOrDown, busy, done, cfg_err, sweep_cnt);
         n_err++;
      end
      tick();
      reset = 1'b0;
      tick();
      lo = 4'd3; hi = 4'd5; sweeps = 4'd1; start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         start = 1'b0;
         if (busy) nbusy++;
         if (done) ndone++;
         if (!busy && i > 0) break;
      end
      n_vec++;
      if (nbusy != 6 || ndone != 1 || Count !== 4'd3 || sweep_cnt !== 4'd1) begin
         $display("FAIL post_reset_run: got busy_cycles=%0d dones=%0d Count=%0d sc=%0d, want 6 1 3 1",
                  nbusy, ndone, Count, sweep_cnt);
         n_err++;
      end
   endtask

   task automatic test_restart_ignored();
      logic [3:0] exp_cnt [6] = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2};
      int         nbad = 0;
      lo = 4'd2; hi = 4'd4; sweeps = 4'd1; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         // Keep hammering start with a different program while running
         lo = 4'd0; hi = 4'd9; sweeps = 4'd5; start = (i < 4);
         if (Count !== exp_cnt[i] || busy !== 1'b1) nbad++;
      end
      n_vec++;
      if (nbad != 0) begin
         $display("FAIL restart_sequence: got %0d wrong cycles, want 0", nbad);
         n_err++;
      end
      start = 1'b0;
      tick();
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || Count !== 4'd2 || sweep_cnt !== 4'd1) begin
         $display("FAIL restart_done_timing: got done=%0b busy=%0b Count=%0d sc=%0d, want 1 0 2 1",
                  done, busy, Count, sweep_cnt);
         n_err++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_range();
      test_cfg_err();
      test_abort();
      test_reset_mid_run();
      test_restart_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
